// File: rtl/ssp_sched_pkg.sv
// Shared definitions for the dual-issue scheduler: opcodes, instruction
// classes, FSM state encodings and the field-extract / decode helpers.
package ssp_sched_pkg;

    localparam int unsigned REG_W = 5;

    // Opcode map (instr[31:26])
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_ORI  = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h18;
    localparam logic [5:0] OP_BNE  = 6'h19;
    localparam logic [5:0] OP_BLT  = 6'h1A;
    localparam logic [5:0] OP_BGE  = 6'h1B;
    localparam logic [5:0] OP_J    = 6'h1C;
    localparam logic [5:0] OP_JAL  = 6'h1D;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BR,
        CLS_JMP,
        CLS_NOP
    } iclass_e;

    // Scheduler FSM encodings
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_BR_WAIT = 1'b1;

    // Register usage of one decoded slot
    typedef struct packed {
        iclass_e          cls;
        logic             src0_v;
        logic [REG_W-1:0] src0;
        logic             src1_v;
        logic [REG_W-1:0] src1;
        logic             dst_v;
        logic [REG_W-1:0] dst;
    } dec_t;

    function automatic logic [5:0] f_op(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [REG_W-1:0] f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [REG_W-1:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [REG_W-1:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    // Classify an instruction and extract the registers it reads/writes.
    // Unallocated opcodes are treated as NOP: consumed, never issued.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.cls    = CLS_NOP;
        d.src0_v = 1'b0;
        d.src0   = f_rs(instr);
        d.src1_v = 1'b0;
        d.src1   = f_rt(instr);
        d.dst_v  = 1'b0;
        d.dst    = '0;
        case (f_op(instr))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d.cls    = CLS_ALU;
                d.src0_v = 1'b1;
                d.src1_v = 1'b1;
                d.dst_v  = 1'b1;
                d.dst    = f_rd(instr);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                d.cls    = CLS_ALU;
                d.src0_v = 1'b1;
                d.dst_v  = 1'b1;
                d.dst    = f_rt(instr);
            end
            OP_LW: begin
                d.cls    = CLS_MEM;
                d.src0_v = 1'b1;
                d.dst_v  = 1'b1;
                d.dst    = f_rt(instr);
            end
            OP_SW: begin
                d.cls    = CLS_MEM;
                d.src0_v = 1'b1;
                d.src1_v = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
                d.cls    = CLS_BR;
                d.src0_v = 1'b1;
                d.src1_v = 1'b1;
            end
            OP_J: begin
                d.cls = CLS_JMP;
            end
            OP_JAL: begin
                d.cls   = CLS_JMP;
                d.dst_v = 1'b1;
                d.dst   = 5'd31;
            end
            default: begin
                d.cls = CLS_NOP;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ssp_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register,
// two set ports (issue lanes) and two clear ports (writeback lanes).
// A set and a clear of the same register in one cycle leaves it busy.
module ssp_scoreboard #(
    parameter  int unsigned NREG  = 32,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             set0_i,
    input  logic [IDX_W-1:0] set0_idx_i,
    input  logic             set1_i,
    input  logic [IDX_W-1:0] set1_idx_i,
    input  logic             clr0_i,
    input  logic [IDX_W-1:0] clr0_idx_i,
    input  logic             clr1_i,
    input  logic [IDX_W-1:0] clr1_idx_i,
    output logic [NREG-1:0]  busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears applied first so a same-cycle set takes priority
    always_comb begin
        busy_d = busy_q;
        if (clr0_i) busy_d[clr0_idx_i] = 1'b0;
        if (clr1_i) busy_d[clr1_idx_i] = 1'b0;
        if (set0_i) busy_d[set0_idx_i] = 1'b1;
        if (set1_i) busy_d[set1_idx_i] = 1'b1;
    end

    // Busy-bit register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Lookup reflects registered state only; a clear shows up next cycle
    assign busy_o = busy_q;

endmodule

// File: rtl/ssp_issue_scheduler.sv
// Dual-issue in-order scheduler between fetch and the two execute lanes.
// Issues 0/1/2 instructions per cycle subject to scoreboard hazards, an
// intra-pair dependency check and the single memory port, and holds issue
// after any branch/jump until the branch unit resolves it.
// Optional: define SCHED_PERF_CNT_EN to add the perf_dual/perf_single/
// perf_stall cycle counters.
module ssp_issue_scheduler
    import ssp_sched_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32
`ifdef SCHED_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            pair_valid,
    input  logic [XLEN-1:0] instr0,
    input  logic [XLEN-1:0] instr1,
    output logic [1:0]      consume,
    output logic            issue0_valid,
    output logic [XLEN-1:0] issue0_instr,
    output logic            issue1_valid,
    output logic [XLEN-1:0] issue1_instr,
    input  logic            wb0_valid,
    input  logic [4:0]      wb0_rd,
    input  logic            wb1_valid,
    input  logic [4:0]      wb1_rd,
    input  logic            br_resolve,
    input  logic            br_taken,
    output logic            flush
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_dual,
    output logic [CNT_W-1:0] perf_single,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    localparam int unsigned IDX_W = $clog2(NREG);

    logic [0:0]      state_q, state_d;
    logic            issue0_valid_q, issue0_valid_d;
    logic            issue1_valid_q, issue1_valid_d;
    logic [XLEN-1:0] issue0_instr_q, issue0_instr_d;
    logic [XLEN-1:0] issue1_instr_q, issue1_instr_d;
    logic            flush_q, flush_d;
    logic [1:0]      consume_c;

    dec_t            d0, d1;
    logic [NREG-1:0] busy;
    logic            blk0, blk1, dep1, ctl0, ctl1, mem_pair;
    logic            take1, iss0, iss1;

    assign d0 = decode(instr0[31:0]);
    assign d1 = decode(instr1[31:0]);

    // Hazard terms: scoreboard RAW/WAW per slot, plus slot1 against slot0's dst
    always_comb begin
        blk0 = (d0.src0_v && busy[d0.src0]) ||
               (d0.src1_v && busy[d0.src1]) ||
               (d0.dst_v  && busy[d0.dst]);
        blk1 = (d1.src0_v && busy[d1.src0]) ||
               (d1.src1_v && busy[d1.src1]) ||
               (d1.dst_v  && busy[d1.dst]);
        dep1 = d0.dst_v && ((d1.src0_v && (d1.src0 == d0.dst)) ||
                            (d1.src1_v && (d1.src1 == d0.dst)) ||
                            (d1.dst_v  && (d1.dst  == d0.dst)));
        ctl0     = (d0.cls == CLS_BR) || (d0.cls == CLS_JMP);
        ctl1     = (d1.cls == CLS_BR) || (d1.cls == CLS_JMP);
        mem_pair = (d0.cls == CLS_MEM) && (d1.cls == CLS_MEM);
    end

    // Next-state, issue decision and registered-output next values
    always_comb begin
        state_d        = state_q;
        consume_c      = 2'd0;
        take1          = 1'b0;
        iss0           = 1'b0;
        iss1           = 1'b0;
        flush_d        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pair_valid && !blk0) begin
                    take1     = !ctl0 && !blk1 && !dep1 && !mem_pair;
                    consume_c = take1 ? 2'd2 : 2'd1;
                    iss0      = (d0.cls != CLS_NOP);
                    iss1      = take1 && (d1.cls != CLS_NOP);
                    if (ctl0 || (take1 && ctl1)) state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (br_resolve) begin
                    state_d = ST_RUN;
                    flush_d = br_taken;
                end
            end
            default: state_d = ST_RUN;
        endcase
        issue0_valid_d = iss0;
        issue1_valid_d = iss1;
        issue0_instr_d = iss0 ? instr0 : issue0_instr_q;
        issue1_instr_d = iss1 ? instr1 : issue1_instr_q;
    end

    // FSM state register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Issue lanes and flush pulse
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            issue0_valid_q <= 1'b0;
            issue1_valid_q <= 1'b0;
            issue0_instr_q <= '0;
            issue1_instr_q <= '0;
            flush_q        <= 1'b0;
        end else begin
            issue0_valid_q <= issue0_valid_d;
            issue1_valid_q <= issue1_valid_d;
            issue0_instr_q <= issue0_instr_d;
            issue1_instr_q <= issue1_instr_d;
            flush_q        <= flush_d;
        end
    end

    ssp_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk1       (clk1),
        .reset      (reset),
        .set0_i     (iss0 && d0.dst_v),
        .set0_idx_i (IDX_W'(d0.dst)),
        .set1_i     (iss1 && d1.dst_v),
        .set1_idx_i (IDX_W'(d1.dst)),
        .clr0_i     (wb0_valid),
        .clr0_idx_i (IDX_W'(wb0_rd)),
        .clr1_i     (wb1_valid),
        .clr1_idx_i (IDX_W'(wb1_rd)),
        .busy_o     (busy)
    );

    assign consume      = consume_c;
    assign issue0_valid = issue0_valid_q;
    assign issue1_valid = issue1_valid_q;
    assign issue0_instr = issue0_instr_q;
    assign issue1_instr = issue1_instr_q;
    assign flush        = flush_q;

`ifdef SCHED_PERF_CNT_EN
    logic [CNT_W-1:0] perf_dual_q, perf_single_q, perf_stall_q;

    // Issue-width and stall cycle counters, free-running with wrap
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (consume_c == 2'd2)              perf_dual_q   <= perf_dual_q + CNT_W'(1);
            if (consume_c == 2'd1)              perf_single_q <= perf_single_q + CNT_W'(1);
            if (pair_valid && consume_c == 2'd0) perf_stall_q <= perf_stall_q + CNT_W'(1);
        end
    end

    assign perf_dual   = perf_dual_q;
    assign perf_single = perf_single_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
